// File: rtl/word_align_fsm.sv
// Word-alignment controller for the LVDS 7:1 receive path (sclk domain).
// Compares clock-lane words to CLK_PATTERN, issues spaced slip pulses,
// declares/drops lock with hysteresis and flags failure when slips run out.
// Optional build macro: WORD_ALIGN_AUTO_RETRY_EN (FAIL retries after 256 cycles).
module word_align_fsm #(
    parameter int unsigned WORD_WIDTH   = 7,
    parameter logic [31:0] CLK_PATTERN  = 32'b1100011,
    parameter int unsigned SLIP_WAIT    = 8,
    parameter int unsigned LOCK_COUNT   = 4,
    parameter int unsigned UNLOCK_COUNT = 3,
    parameter int unsigned MAX_SLIPS    = 2 * WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  align_enable,
    input  logic [WORD_WIDTH-1:0] clock_word,
    output logic                  slip,
    output logic                  clock_word_lock,
    output logic                  align_fail,
    output logic [7:0]            slip_count
);

    localparam int unsigned MC_W = 4;
    localparam int unsigned WC_W = 6;
    localparam int unsigned SC_W = 8;
    localparam logic [WORD_WIDTH-1:0] PATTERN = CLK_PATTERN[WORD_WIDTH-1:0];

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CHECK  = 3'd1;
    localparam logic [2:0] S_SLIP   = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_LOCKED = 3'd4;
    localparam logic [2:0] S_FAIL   = 3'd5;

    logic [2:0]      r_state,      w_state_nxt;
    logic [MC_W-1:0] r_match_cnt,  w_match_cnt_nxt;
    logic [MC_W-1:0] r_miss_cnt,   w_miss_cnt_nxt;
    logic [WC_W-1:0] r_wait_cnt,   w_wait_cnt_nxt;
    logic [SC_W-1:0] r_slip_count, w_slip_count_nxt;
    logic            r_slip,       w_slip_nxt;
    logic            r_lock,       w_lock_nxt;
    logic            r_fail,       w_fail_nxt;
    logic            w_match;
`ifdef WORD_ALIGN_AUTO_RETRY_EN
    logic [7:0]      r_fail_cnt,   w_fail_cnt_nxt;
`endif

    assign w_match         = (clock_word == PATTERN);
    assign slip            = r_slip;
    assign clock_word_lock = r_lock;
    assign align_fail      = r_fail;
    assign slip_count      = r_slip_count;

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_match_cnt  <= '0;
            r_miss_cnt   <= '0;
            r_wait_cnt   <= '0;
            r_slip_count <= '0;
            r_slip       <= 1'b0;
            r_lock       <= 1'b0;
            r_fail       <= 1'b0;
`ifdef WORD_ALIGN_AUTO_RETRY_EN
            r_fail_cnt   <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_match_cnt  <= w_match_cnt_nxt;
            r_miss_cnt   <= w_miss_cnt_nxt;
            r_wait_cnt   <= w_wait_cnt_nxt;
            r_slip_count <= w_slip_count_nxt;
            r_slip       <= w_slip_nxt;
            r_lock       <= w_lock_nxt;
            r_fail       <= w_fail_nxt;
`ifdef WORD_ALIGN_AUTO_RETRY_EN
            r_fail_cnt   <= w_fail_cnt_nxt;
`endif
        end
    end

    // Next-state, next-counter and next-output decode
    always_comb begin
        w_state_nxt      = r_state;
        w_match_cnt_nxt  = r_match_cnt;
        w_miss_cnt_nxt   = r_miss_cnt;
        w_wait_cnt_nxt   = r_wait_cnt;
        w_slip_count_nxt = r_slip_count;
        w_slip_nxt       = 1'b0;
        w_lock_nxt       = r_lock;
        w_fail_nxt       = r_fail;
`ifdef WORD_ALIGN_AUTO_RETRY_EN
        w_fail_cnt_nxt   = r_fail_cnt;
`endif

        if (!align_enable) begin
            // Disable wins over everything: back to a clean idle
            w_state_nxt      = S_IDLE;
            w_match_cnt_nxt  = '0;
            w_miss_cnt_nxt   = '0;
            w_wait_cnt_nxt   = '0;
            w_slip_count_nxt = '0;
            w_lock_nxt       = 1'b0;
            w_fail_nxt       = 1'b0;
`ifdef WORD_ALIGN_AUTO_RETRY_EN
            w_fail_cnt_nxt   = '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt      = S_CHECK;
                    w_match_cnt_nxt  = '0;
                    w_slip_count_nxt = '0;
                    w_lock_nxt       = 1'b0;
                    w_fail_nxt       = 1'b0;
                end
                S_CHECK: begin
                    if (w_match) begin
                        if (({1'b0, r_match_cnt} + 5'd1) == 5'(LOCK_COUNT)) begin
                            w_state_nxt    = S_LOCKED;
                            w_lock_nxt     = 1'b1;
                            w_fail_nxt     = 1'b0;
                            w_miss_cnt_nxt = '0;
                        end else begin
                            w_match_cnt_nxt = r_match_cnt + MC_W'(1);
                        end
                    end else if (r_slip_count == SC_W'(MAX_SLIPS)) begin
                        w_state_nxt = S_FAIL;
                        w_fail_nxt  = 1'b1;
                        w_lock_nxt  = 1'b0;
`ifdef WORD_ALIGN_AUTO_RETRY_EN
                        w_fail_cnt_nxt = '0;
`endif
                    end else begin
                        w_match_cnt_nxt = '0;
                        w_state_nxt     = S_SLIP;
                        w_slip_nxt      = 1'b1;
                    end
                end
                S_SLIP: begin
                    if (r_slip_count != 8'hFF) begin
                        w_slip_count_nxt = r_slip_count + SC_W'(1);
                    end
                    w_wait_cnt_nxt = '0;
                    w_state_nxt    = S_WAIT;
                end
                S_WAIT: begin
                    if (r_wait_cnt == WC_W'(SLIP_WAIT - 1)) begin
                        w_state_nxt     = S_CHECK;
                        w_match_cnt_nxt = '0;
                    end else begin
                        w_wait_cnt_nxt = r_wait_cnt + WC_W'(1);
                    end
                end
                S_LOCKED: begin
                    if (w_match) begin
                        w_miss_cnt_nxt = '0;
                    end else if (({1'b0, r_miss_cnt} + 5'd1) == 5'(UNLOCK_COUNT)) begin
                        w_state_nxt      = S_CHECK;
                        w_lock_nxt       = 1'b0;
                        w_slip_count_nxt = '0;
                        w_match_cnt_nxt  = '0;
                        w_miss_cnt_nxt   = '0;
                    end else begin
                        w_miss_cnt_nxt = r_miss_cnt + MC_W'(1);
                    end
                end
                S_FAIL: begin
`ifdef WORD_ALIGN_AUTO_RETRY_EN
                    // Retry after 256 cycles; align_fail stays set until the next lock
                    if (r_fail_cnt == 8'hFF) begin
                        w_state_nxt      = S_CHECK;
                        w_slip_count_nxt = '0;
                        w_match_cnt_nxt  = '0;
                        w_fail_cnt_nxt   = '0;
                    end else begin
                        w_fail_cnt_nxt = r_fail_cnt + 8'd1;
                    end
`else
                    w_state_nxt = S_FAIL;
`endif
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

endmodule
